ex_sat_flag_stage: RTL and testbench
====================================

# ex_sat_flag_stage

Execute-stage back end that consumes the 16-bit adder's Sum and overflow outputs. It saturates ADD/SUB results on signed overflow, maintains the architectural Z/V/N condition-flag register, and registers the result into the EX/MEM pipeline boundary with stall and flush control. The stage has one clock of latency and sits between the ALU adder and the memory stage.

## Interface
- No parameters. Data width is fixed at 16 bits and the register index at 4 bits.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  an EX instruction is present this cycle.
- stall  in  1  hold every register (MEM not ready).
- flush  in  1  replace the incoming instruction with a bubble.
- op  in  2  00 ADD, 01 SUB, 10 LOGIC, 11 PASS.
- sum_in  in  16  raw adder Sum, or the logic/pass value.
- a_msb  in  1  bit 15 of adder operand A.
- ovf_in  in  1  adder signed-overflow flag.
- rd_in  in  4  destination register index.
- wr_en_in  in  1  instruction writes rd.
- out_valid  out  1  registered valid for MEM.
- result_out  out  16  registered (saturated) result.
- rd_out  out  4  registered destination index.
- wr_en_out  out  1  registered write enable; forced 0 when out_valid is 0.
- flag_z, flag_v, flag_n  out  1 each  architectural condition flags.

## Operation
- Accept condition: accept = in_valid & ~stall & ~flush.
- Saturation applies only when op is ADD or SUB and ovf_in=1.
  - a_msb=0 gives 16'h7FFF.
  - a_msb=1 gives 16'h8000.
  - SUB uses the same rule because the adder computes A + ~B + 1 and overflow direction follows A's sign.
- In every other case, res = sum_in unchanged, including LOGIC and PASS with ovf_in=1.
- Flag updates happen only on accept:
  - ADD/SUB: Z = (res==0), V = ovf_in, N = res[15]. Z and N are taken from the saturated value.
  - LOGIC: Z = (res==0); V and N hold.
  - PASS: no flag change.
- Pipeline register behaviour:
  - On accept: out_valid=1, and result_out, rd_out and wr_en_out load res, rd_in and wr_en_in.
  - ~in_valid with no stall: out_valid=0, wr_en_out=0. result_out and rd_out may hold.
- Flush:
  - Flush with no stall: out_valid=0, wr_en_out=0, flags unchanged.
  - Flush has priority over stall. When both are asserted, the bubble is inserted and the flags hold.
- Stall without flush: every output register and flag holds its value, whatever in_valid is.
- There is no state machine beyond the valid bit. Each cycle is exactly one of hold, load or bubble.

## Timing
- Reset (rst_n=0, asynchronous, takes effect immediately without waiting for a clock edge):
  - out_valid=0, result_out=16'h0000, rd_out=4'h0, wr_en_out=0.
  - flag_z=0, flag_v=0, flag_n=0.
- Latency: inputs accepted at rising edge k appear on the outputs after edge k; the flags are valid in cycle k+1.
- Flags written at edge k are visible to a branch in cycle k+1. No same-cycle bypass is provided.
- Back-to-back accepts every cycle are supported, giving a throughput of 1 per clock.
- Asserting rst_n low during a stall or flush overrides both. Deasserting it synchronously to clk is the system's responsibility.
- Inputs only need to be stable around the rising edge. The saturation mux is combinational ahead of the register.

## Test plan
- Reset:
  - Drive garbage inputs with rst_n=0 and check all outputs are 0.
  - Pulse rst_n low between clock edges while out_valid=1 with result 16'h1234. All outputs must clear immediately.
- Positive saturation:
  - Stimulus: op=ADD, sum_in=16'h9000, ovf_in=1, a_msb=0, rd_in=3, wr_en_in=1.
  - Next cycle: result_out=16'h7FFF, rd_out=3, wr_en_out=1, Z=0, V=1, N=0.
- Negative saturation:
  - Stimulus: op=SUB, sum_in=16'h7FF0, ovf_in=1, a_msb=1.
  - Required: result_out=16'h8000, V=1, N=1, Z=0.
  - Repeat with no overflow: sum_in=16'h0000, ovf_in=0 gives result 16'h0000, Z=1, V=0, N=0.
- Partial flag update:
  - Setup: after the previous step leaves V=1, N=1, issue op=LOGIC, sum_in=16'h0000, ovf_in=1.
  - Required: result 16'h0000 (not saturated), Z=1, V=1, N=1.
  - Then issue op=PASS, sum_in=16'h00FF. Required: all flags unchanged.
- Stall/flush interaction:
  - With out_valid=1 and result 16'hABCD, assert stall for 3 cycles while presenting new ADD data. Outputs and flags must hold 16'hABCD.
  - Then assert stall=1 and flush=1 together. Next cycle: out_valid=0, wr_en_out=0, flags unchanged.
- Throughput:
  - Stream 4 consecutive accepts with sum_in 1, 2, 3, 16'hFFFF (ADD, no overflow).
  - Required: result_out 1, 2, 3, 16'hFFFF on consecutive cycles, and N=1 only after the last.

Source files
------------

// File: rtl/ex_sat_flag_stage_if.sv
//==============================================================================
// Module      : ex_sat_flag_stage_if
// Description : Signal bundle between the EX adder front end and the
//               saturation/flag/EX-MEM register stage.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface ex_sat_flag_stage_if;
  // Upstream instruction and adder outputs
  logic        in_valid;
  logic        stall;
  logic        flush;
  logic [1:0]  op;
  logic [15:0] sum_in;
  logic        a_msb;
  logic        ovf_in;
  logic [3:0]  rd_in;
  logic        wr_en_in;

  // EX/MEM register outputs and architectural flags
  logic        out_valid;
  logic [15:0] result_out;
  logic [3:0]  rd_out;
  logic        wr_en_out;
  logic        flag_z;
  logic        flag_v;
  logic        flag_n;

  // Producer side: drives the instruction and observes the stage outputs
  modport master (
    output in_valid, stall, flush, op, sum_in, a_msb, ovf_in, rd_in, wr_en_in,
    input  out_valid, result_out, rd_out, wr_en_out, flag_z, flag_v, flag_n
  );

  // Stage side
  modport slave (
    input  in_valid, stall, flush, op, sum_in, a_msb, ovf_in, rd_in, wr_en_in,
    output out_valid, result_out, rd_out, wr_en_out, flag_z, flag_v, flag_n
  );
endinterface

`default_nettype wire

// File: rtl/ex_sat_flag_stage.sv
//==============================================================================
// Module      : ex_sat_flag_stage
// Description : Execute-stage back end. Saturates ADD/SUB results on signed
//               overflow, maintains the Z/V/N flag register and registers the
//               result into the EX/MEM boundary with stall and flush control.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ex_sat_flag_stage (
  input  logic                  clk,
  input  logic                  rst_n,
  ex_sat_flag_stage_if.slave    bus
);

  localparam logic [1:0]  c_OP_ADD   = 2'b00;
  localparam logic [1:0]  c_OP_SUB   = 2'b01;
  localparam logic [1:0]  c_OP_LOGIC = 2'b10;
  localparam logic [15:0] c_SAT_POS  = 16'h7FFF;
  localparam logic [15:0] c_SAT_NEG  = 16'h8000;

  logic        valid_q,  valid_d;
  logic [15:0] result_q, result_d;
  logic [3:0]  rd_q,     rd_d;
  logic        wr_en_q,  wr_en_d;
  logic        z_q,      z_d;
  logic        v_q,      v_d;
  logic        n_q,      n_d;

  logic        w_accept;
  logic        w_arith;
  logic [15:0] w_res;

  // Saturation mux and next-state selection: each cycle is hold, load or bubble
  always_comb begin
    w_accept = bus.in_valid & ~bus.stall & ~bus.flush;
    w_arith  = (bus.op == c_OP_ADD) || (bus.op == c_OP_SUB);
    // Overflow direction follows A's sign for both ADD and SUB (A + ~B + 1)
    if (w_arith && bus.ovf_in) begin
      w_res = bus.a_msb ? c_SAT_NEG : c_SAT_POS;
    end else begin
      w_res = bus.sum_in;
    end

    valid_d  = valid_q;
    result_d = result_q;
    rd_d     = rd_q;
    wr_en_d  = wr_en_q;
    z_d      = z_q;
    v_d      = v_q;
    n_d      = n_q;

    // Flush wins over stall; a stall alone freezes everything
    if (bus.flush || !bus.stall) begin
      if (w_accept) begin
        valid_d  = 1'b1;
        result_d = w_res;
        rd_d     = bus.rd_in;
        wr_en_d  = bus.wr_en_in;
        if (w_arith) begin
          z_d = (w_res == 16'h0000);
          v_d = bus.ovf_in;
          n_d = w_res[15];
        end else if (bus.op == c_OP_LOGIC) begin
          z_d = (w_res == 16'h0000);
        end
      end else begin
        valid_d = 1'b0;
        wr_en_d = 1'b0;
      end
    end
  end

  // EX/MEM pipeline register and flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      result_q <= 16'h0000;
      rd_q     <= 4'h0;
      wr_en_q  <= 1'b0;
      z_q      <= 1'b0;
      v_q      <= 1'b0;
      n_q      <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      rd_q     <= rd_d;
      wr_en_q  <= wr_en_d;
      z_q      <= z_d;
      v_q      <= v_d;
      n_q      <= n_d;
    end
  end

  assign bus.out_valid  = valid_q;
  assign bus.result_out = result_q;
  assign bus.rd_out     = rd_q;
  assign bus.wr_en_out  = wr_en_q;
  assign bus.flag_z     = z_q;
  assign bus.flag_v     = v_q;
  assign bus.flag_n     = n_q;

endmodule

`default_nettype wire

// File: tb/tb_ex_sat_flag_stage.sv
//==============================================================================
// Module      : tb_ex_sat_flag_stage
// Description : Self-checking bench for ex_sat_flag_stage.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ex_sat_flag_stage;

  localparam logic [1:0] c_ADD   = 2'b00;
  localparam logic [1:0] c_SUB   = 2'b01;
  localparam logic [1:0] c_LOGIC = 2'b10;
  localparam logic [1:0] c_PASS  = 2'b11;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  ex_sat_flag_stage_if bus ();

  ex_sat_flag_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {valid, result, rd, wr_en, z, v, n}
  function automatic logic [24:0] obs();
    return {bus.out_valid, bus.result_out, bus.rd_out, bus.wr_en_out,
            bus.flag_z, bus.flag_v, bus.flag_n};
  endfunction

  task automatic drive(input logic v, input logic st, input logic fl,
                       input logic [1:0] op, input logic [15:0] sum,
                       input logic amsb, input logic ovf,
                       input logic [3:0] rd, input logic wr);
    bus.in_valid = v;   bus.stall  = st;  bus.flush = fl;
    bus.op       = op;  bus.sum_in = sum; bus.a_msb = amsb;
    bus.ovf_in   = ovf; bus.rd_in  = rd;  bus.wr_en_in = wr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [24:0] o;
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 1'b0, c_ADD, 16'hDEAD, 1'b1, 1'b1, 4'hF, 1'b1);
    tick(); tick();
    o = obs();
    checks++;
    if (o !== 25'h0) begin
      $display("FAIL reset_hold: got %h want %h", o, 25'h0);
      failures++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0, c_PASS, 16'h1234, 1'b0, 1'b0, 4'h2, 1'b1);
    tick();
    o = obs();
    checks++;
    if (o !== {1'b1, 16'h1234, 4'h2, 1'b1, 3'b000}) begin
      $display("FAIL reset_load1234: got %h want %h", o, {1'b1, 16'h1234, 4'h2, 1'b1, 3'b000});
      failures++;
    end
    // Mid-cycle asynchronous pulse
    #2 rst_n = 1'b0;
    #1;
    o = obs();
    checks++;
    if (o !== 25'h0) begin
      $display("FAIL reset_async: got %h want %h", o, 25'h0);
      failures++;
    end
    #1 rst_n = 1'b1;
  endtask

  task automatic test_pos_sat();
    logic [24:0] o;
    logic [24:0] e;
    drive(1'b1, 1'b0, 1'b0, c_ADD, 16'h9000, 1'b0, 1'b1, 4'd3, 1'b1);
    tick();
    o = obs(); e = {1'b1, 16'h7FFF, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0};
    checks++;
    if (o !== e) begin
      $display("FAIL pos_sat: got %h want %h", o, e);
      failures++;
    end
  endtask

  task automatic test_neg_sat();
    logic [24:0] o;
    logic [24:0] e;
    drive(1'b1, 1'b0, 1'b0, c_SUB, 16'h7FF0, 1'b1, 1'b1, 4'd5, 1'b1);
    tick();
    o = obs(); e = {1'b1, 16'h8000, 4'd5, 1'b1, 1'b0, 1'b1, 1'b1};
    checks++;
    if (o !== e) begin
      $display("FAIL neg_sat: got %h want %h", o, e);
      failures++;
    end
    drive(1'b1, 1'b0, 1'b0, c_SUB, 16'h0000, 1'b1, 1'b0, 4'd5, 1'b1);
    tick();
    o = obs(); e = {1'b1, 16'h0000, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0};
    checks++;
    if (o !== e) begin
      $display("FAIL sub_zero: got %h want %h", o, e);
      failures++;
    end
  endtask

  task automatic test_partial_flags();
    logic [24:0] o;
    logic [24:0] e;
    drive(1'b1, 1'b0, 1'b0, c_SUB, 16'h7FF0, 1'b1, 1'b1, 4'd5, 1'b1);
    tick();
    o = obs(); e = {1'b1, 16'h8000, 4'd5, 1'b1, 1'b0, 1'b1, 1'b1};
    checks++;
    if (o !== e) begin
      $display("FAIL partial_setup: got %h want %h", o, e);
      failures++;
    end
    drive(1'b1, 1'b0, 1'b0, c_LOGIC, 16'h0000, 1'b0, 1'b1, 4'd6, 1'b1);
    tick();
    o = obs(); e = {1'b1, 16'h0000, 4'd6, 1'b1, 1'b1, 1'b1, 1'b1};
    checks++;
    if (o !== e) begin
      $display("FAIL logic_zero: got %h want %h", o, e);
      failures++;
    end
    drive(1'b1, 1'b0, 1'b0, c_PASS, 16'h00FF, 1'b0, 1'b1, 4'd7, 1'b0);
    tick();
    o = obs(); e = {1'b1, 16'h00FF, 4'd7, 1'b0, 1'b1, 1'b1, 1'b1};
    checks++;
    if (o !== e) begin
      $display("FAIL pass_hold: got %h want %h", o, e);
      failures++;
    end
    drive(1'b1, 1'b0, 1'b0, c_LOGIC, 16'h8001, 1'b0, 1'b1, 4'd8, 1'b1);
    tick();
    o = obs(); e = {1'b1, 16'h8001, 4'd8, 1'b1, 1'b0, 1'b1, 1'b1};
    checks++;
    if (o !== e) begin
      $display("FAIL logic_nonzero: got %h want %h", o, e);
      failures++;
    end
  endtask

  task automatic test_stall_flush();
    logic [24:0] o;
    logic [24:0] e;
    logic [4:0]  os;
    drive(1'b1, 1'b0, 1'b0, c_ADD, 16'hABCD, 1'b1, 1'b0, 4'd9, 1'b1);
    tick();
    e = {1'b1, 16'hABCD, 4'd9, 1'b1, 1'b0, 1'b0, 1'b1};
    o = obs();
    checks++;
    if (o !== e) begin
      $display("FAIL load_abcd: got %h want %h", o, e);
      failures++;
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, c_ADD, 16'h0000 + 16'(i), 1'b0, 1'b1, 4'd1, 1'b0);
      tick();
      o = obs();
      checks++;
      if (o !== e) begin
        $display("FAIL stall_hold%0d: got %h want %h", i, o, e);
        failures++;
      end
    end
    // Flush together with stall: bubble, flags hold
    drive(1'b1, 1'b1, 1'b1, c_ADD, 16'h0000, 1'b0, 1'b1, 4'd1, 1'b1);
    tick();
    os = {bus.out_valid, bus.wr_en_out, bus.flag_z, bus.flag_v, bus.flag_n};
    checks++;
    if (os !== 5'b00_001) begin
      $display("FAIL stall_flush: got %b want %b", os, 5'b00_001);
      failures++;
    end
    // Flush alone with ADD data that would change flags
    drive(1'b1, 1'b0, 1'b0, c_ADD, 16'h1111, 1'b0, 1'b0, 4'd2, 1'b1);
    tick();
    drive(1'b1, 1'b0, 1'b1, c_ADD, 16'h0000, 1'b1, 1'b1, 4'd3, 1'b1);
    tick();
    os = {bus.out_valid, bus.wr_en_out, bus.flag_z, bus.flag_v, bus.flag_n};
    checks++;
    if (os !== 5'b00_000) begin
      $display("FAIL flush_only: got %b want %b", os, 5'b00_000);
      failures++;
    end
    // No valid instruction: bubble
    drive(1'b1, 1'b0, 1'b0, c_ADD, 16'h8000, 1'b0, 1'b0, 4'd2, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, c_ADD, 16'h0000, 1'b0, 1'b1, 4'd2, 1'b1);
    tick();
    os = {bus.out_valid, bus.wr_en_out, bus.flag_z, bus.flag_v, bus.flag_n};
    checks++;
    if (os !== 5'b00_001) begin
      $display("FAIL idle_bubble: got %b want %b", os, 5'b00_001);
      failures++;
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] sums [4];
    logic [24:0] o;
    logic [24:0] e;
    sums[0] = 16'h0001; sums[1] = 16'h0002; sums[2] = 16'h0003; sums[3] = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, c_ADD, sums[i], 1'b0, 1'b0, 4'(i + 1), 1'b1);
      tick();
      o = obs();
      e = {1'b1, sums[i], 4'(i + 1), 1'b1, 1'b0, 1'b0, (i == 3)};
      checks++;
      if (o !== e) begin
        $display("FAIL stream%0d: got %h want %h", i, o, e);
        failures++;
      end
    end
  endtask

  task automatic test_random();
    // Reference state, re-derived from the operation rules
    bit m_valid, m_wr, m_z, m_v, m_n;
    int m_res, m_rd;
    int res;
    bit v, st, fl, amsb, ovf, wr;
    int op, sum, rd;
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    m_valid = 0; m_wr = 0; m_z = 0; m_v = 0; m_n = 0; m_res = 0; m_rd = 0;
    for (int i = 0; i < 300; i++) begin
      v    = ($urandom_range(0, 9) < 8);
      st   = ($urandom_range(0, 9) < 2);
      fl   = ($urandom_range(0, 9) < 1);
      op   = int'($urandom_range(0, 3));
      sum  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 65535));
      amsb = $urandom_range(0, 1) == 1;
      ovf  = $urandom_range(0, 2) == 0;
      rd   = int'($urandom_range(0, 15));
      wr   = $urandom_range(0, 1) == 1;
      drive(v, st, fl, 2'(op), 16'(sum), amsb, ovf, 4'(rd), wr);

      if (fl) begin
        m_valid = 0; m_wr = 0;
      end else if (!st) begin
        if (v) begin
          if (op <= 1 && ovf) res = amsb ? 32768 : 32767;
          else                res = sum;
          m_valid = 1; m_res = res; m_rd = rd; m_wr = wr;
          if (op <= 1) begin
            m_z = (res == 0); m_v = ovf; m_n = (res >= 32768);
          end else if (op == 2) begin
            m_z = (res == 0);
          end
        end else begin
          m_valid = 0; m_wr = 0;
        end
      end
      tick();

      checks++;
      if ({bus.out_valid, bus.wr_en_out, bus.flag_z, bus.flag_v, bus.flag_n} !==
          {m_valid, m_wr, m_z, m_v, m_n}) begin
        $display("FAIL rand%0d_ctl: got %b want %b", i,
                 {bus.out_valid, bus.wr_en_out, bus.flag_z, bus.flag_v, bus.flag_n},
                 {m_valid, m_wr, m_z, m_v, m_n});
        failures++;
      end
      if (m_valid) begin
        checks++;
        if ({bus.result_out, bus.rd_out} !== {16'(m_res), 4'(m_rd)}) begin
          $display("FAIL rand%0d_data: got %h want %h", i,
                   {bus.result_out, bus.rd_out}, {16'(m_res), 4'(m_rd)});
          failures++;
        end
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    drive(1'b0, 1'b0, 1'b0, c_ADD, 16'h0000, 1'b0, 1'b0, 4'h0, 1'b0);
    test_reset();
    test_pos_sat();
    test_neg_sat();
    test_partial_flags();
    test_stall_flush();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
